neuron_mac: RTL and testbench
=============================

# neuron_mac

Sequential multiply-accumulate core of the artificial neuron: accepts K signed input/weight pairs over a valid/ready stream and produces their signed M-bit dot product. It sits directly upstream of the ReLU activation stage; `sum_out` feeds the activation input unchanged, and `done` marks when that input is valid.

## Interface
- `N`, default 8: width of each signed input `x_in` and weight `w_in` (two's complement).
- `M`, default 18: width of the signed accumulator and `sum_out`; must match the activation stage width.
- `K`, default 4: number of input/weight pairs per dot product (K ≥ 1).

Ports:
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: begin a new dot product; honoured only in IDLE.
- `x_in` input N: signed input sample.
- `w_in` input N: signed weight.
- `in_valid` input 1: `x_in` and `w_in` are valid this cycle.
- `in_ready` output 1: the block accepts a pair this cycle.
- `sum_out` output M: signed dot-product result, registered.
- `done` output 1: one-cycle pulse; `sum_out` holds a new result.
- `busy` output 1: high in ACCUM and DONE.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE:
  - `in_ready`=0.
  - `start`=1 clears the accumulator and pair counter, then moves to ACCUM.
- ACCUM:
  - `in_ready`=1.
  - A pair is accepted on each edge where `in_valid`=1.
  - On acceptance: product = `x_in`×`w_in` as a signed 2N-bit value, sign-extended (or truncated if 2N > M) to M bits, then added to the accumulator.
  - Cycles with `in_valid`=0 are bubbles and leave all state unchanged.
  - On the edge accepting the K-th pair: the final sum is loaded into `sum_out` and the state moves to DONE.
- DONE:
  - `done`=1 for exactly one cycle, then return to IDLE.
  - `in_ready`=0.
- `start` outside IDLE is ignored. It is not queued.
- `sum_out` holds the last result until the next completion. It is not cleared by `start`.
- Pair counter: ⌈log2(K+1)⌉ bits, counts 0..K-1, no wrap.
- Overflow: wraps modulo 2^M by default. See Configuration.
- Asynchronous `rst` at any time, including mid-ACCUM:
  - State goes to IDLE; accumulator, counter and `sum_out` go to 0.
  - `done`, `busy` and `in_ready` go to 0.
  - The partial sum is discarded.

## Timing
- Reset values: `sum_out`=0, `done`=0, `busy`=0, `in_ready`=0.
- Start cycle: `start` sampled at edge t gives ACCUM with `in_ready`=1 from cycle t+1.
- Throughput: one pair per cycle with no bubbles, so K cycles in ACCUM minimum.
- Latency:
  - The K-th pair accepted at edge e makes `sum_out` valid and `done`=1 in the cycle after e.
  - IDLE follows at edge e+1.
  - Minimum start-to-done: K+1 edges.
- Back-to-back operation: a new `start` may be asserted during the `done` cycle but is ignored there. The earliest honoured `start` is the cycle after `done`.
- `start` and `in_valid` both high in IDLE: no pair is accepted (`in_ready`=0).

## Configuration
- `NEURON_MAC_SAT_EN` defined:
  - Each accumulation saturates to the signed M-bit limits, +(2^(M-1)−1) or −2^(M-1).
  - Once saturated, the value stays clamped until a later product moves it back in range.
- `NEURON_MAC_SAT_EN` undefined: plain two's-complement wrap-around modulo 2^M.

## Test plan
- Basic sum (K=4, N=8, M=18): x={1,2,3,4}, w={5,6,7,8} sent back-to-back → `done` pulses one cycle after the 4th pair; `sum_out`=70.
- Negative result: x={−128 ×4}, w={127 ×4} → `sum_out`=−65024 (18'h30200). The downstream ReLU then sees the sign bit set.
- Bubbles: same pairs as the basic-sum test with `in_valid` low on alternating cycles → `sum_out`=70; `done` appears one cycle after the 4th accepted pair.
- Overflow (M=16): x={−128 ×4}, w={−128 ×4} → `sum_out`=16'h7FFF with `NEURON_MAC_SAT_EN`, 16'h0000 without.
- Reset mid-operation: assert `rst` after 2 of 4 pairs → all outputs 0 immediately. A fresh start with x={1,1,1,1}, w={2,2,2,2} then gives `sum_out`=8.
- Ignored start: pulse `start` during ACCUM and during DONE → the counter is not reset, the result is correct, and no extra `done` pulse occurs.

Source files
------------

// File: rtl/neuron_mac_if.sv
// Stream/control bundle for the neuron MAC: pair input handshake, start, and result outputs.
// The master drives start and the input pairs; the slave (the MAC) returns status and sum.
interface neuron_mac_if #(
  parameter int N = 8,
  parameter int M = 18
);
  logic         start;
  logic [N-1:0] x_in;
  logic [N-1:0] w_in;
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] sum_out;
  logic         done;
  logic         busy;

  modport master (
    output start, x_in, w_in, in_valid,
    input  in_ready, sum_out, done, busy
  );

  modport slave (
    input  start, x_in, w_in, in_valid,
    output in_ready, sum_out, done, busy
  );
endinterface

// File: rtl/neuron_mac.sv
// Sequential signed MAC: K pairs in over valid/ready, signed M-bit dot product out.
// Define NEURON_MAC_SAT_EN to clamp each accumulation instead of wrapping modulo 2^M.
module neuron_mac #(
  parameter int N = 8,
  parameter int M = 18,
  parameter int K = 4
) (
  input  logic          clk,
  input  logic          rst,
  neuron_mac_if.slave   bus
);
  localparam int CW = $clog2(K + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t               state_q, state_d;
  logic signed [M-1:0]  acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [M-1:0]         sum_q, sum_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 in_ready_q, in_ready_d;

  logic signed [2*N-1:0] prod;
  logic signed [M-1:0]   prod_m;
  logic signed [M-1:0]   acc_next;

  assign prod = $signed(bus.x_in) * $signed(bus.w_in);

  // Fit the full-precision product to the accumulator width.
  generate
    if (M > 2*N) begin : g_ext
      assign prod_m = {{(M-2*N){prod[2*N-1]}}, prod};
    end else if (M == 2*N) begin : g_eq
      assign prod_m = prod;
    end else begin : g_trunc
      assign prod_m = prod[M-1:0];
    end
  endgenerate

`ifdef NEURON_MAC_SAT_EN
  logic signed [M:0] sum_w;
  assign sum_w = {acc_q[M-1], acc_q} + {prod_m[M-1], prod_m};
  // Top two bits disagree only when the true sum left the M-bit range.
  always_comb begin
    acc_next = sum_w[M-1:0];
    if (sum_w[M] != sum_w[M-1])
      acc_next = sum_w[M] ? {1'b1, {(M-1){1'b0}}} : {1'b0, {(M-1){1'b1}}};
  end
`else
  assign acc_next = acc_q + prod_m;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: if (bus.start) begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = ACCUM;
      end
      ACCUM: if (bus.in_valid) begin
        acc_d = acc_next;
        if (cnt_q == CW'(K - 1)) begin
          sum_d   = acc_next;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Status outputs are registered versions of the next state.
    in_ready_d = (state_d == ACCUM);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      sum_q      <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.sum_out  = sum_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: an M=18 and an M=16 instance share the same stimulus.
module tb_neuron_mac;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] x = '0, w = '0;
  logic       in_valid = 1'b0;
  int         n_chk = 0;
  int         n_err = 0;

`ifdef NEURON_MAC_SAT_EN
  localparam logic [15:0] OVF16 = 16'h7FFF;
  localparam logic [15:0] NEG16 = 16'h8000;
`else
  localparam logic [15:0] OVF16 = 16'h0000;
  localparam logic [15:0] NEG16 = 16'h0200;
`endif

  always #5 clk = ~clk;

  neuron_mac_if #(.N(8), .M(18)) ba ();
  neuron_mac_if #(.N(8), .M(16)) bb ();

  assign ba.start = start;  assign bb.start = start;
  assign ba.x_in = x;       assign bb.x_in = x;
  assign ba.w_in = w;       assign bb.w_in = w;
  assign ba.in_valid = in_valid;  assign bb.in_valid = in_valid;

  neuron_mac #(.N(8), .M(18), .K(4)) u_dut   (.clk(clk), .rst(rst), .bus(ba.slave));
  neuron_mac #(.N(8), .M(16), .K(4)) u_dut16 (.clk(clk), .rst(rst), .bus(bb.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [3:0][7:0] xs, input logic [3:0][7:0] ws,
                        input bit bub, input logic [17:0] e18, input logic [15:0] e16);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ":in_ready"}, 32'(ba.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (bub && i > 0) begin
        in_valid = 1'b0;
        tick();
      end
      x = xs[i];
      w = ws[i];
      in_valid = 1'b1;
      if (i == 3) chk({tag, ":early_done"}, 32'(ba.done), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    chk({tag, ":done"}, 32'(ba.done), 32'd1);
    chk({tag, ":sum18"}, 32'(ba.sum_out), 32'(e18));
    chk({tag, ":done16"}, 32'(bb.done), 32'd1);
    chk({tag, ":sum16"}, 32'(bb.sum_out), 32'(e16));
    tick();
    chk({tag, ":done_clr"}, 32'(ba.done), 32'd0);
    chk({tag, ":busy_clr"}, 32'(ba.busy), 32'd0);
  endtask

  initial begin
    #3;
    chk("rst:sum", 32'(ba.sum_out), 32'd0);
    chk("rst:done", 32'(ba.done), 32'd0);
    chk("rst:busy", 32'(ba.busy), 32'd0);
    chk("rst:in_ready", 32'(ba.in_ready), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle:in_ready", 32'(ba.in_ready), 32'd0);

    run_op("basic", {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 1'b0, 18'd70, 16'd70);
    run_op("neg", {4{8'h80}}, {4{8'h7F}}, 1'b0, 18'h30200, NEG16);
    run_op("bubble", {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 1'b1, 18'd70, 16'd70);
    run_op("ovf", {4{8'h80}}, {4{8'h80}}, 1'b0, 18'h10000, OVF16);

    // Asynchronous reset after two of four pairs.
    start = 1'b1;
    tick();
    start = 1'b0;
    x = 8'd9; w = 8'd9; in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rstmid:sum", 32'(ba.sum_out), 32'd0);
    chk("rstmid:busy", 32'(ba.busy), 32'd0);
    chk("rstmid:in_ready", 32'(ba.in_ready), 32'd0);
    chk("rstmid:done", 32'(ba.done), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    run_op("after_rst", {4{8'd1}}, {4{8'd2}}, 1'b0, 18'd8, 16'd8);

    // start with in_valid in IDLE takes no pair; start in ACCUM/DONE is ignored.
    start = 1'b1; in_valid = 1'b1; x = 8'd100; w = 8'd100;
    tick();
    start = 1'b0;
    chk("ign:in_ready", 32'(ba.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      x = 8'(i + 1);
      w = 8'(i + 5);
      in_valid = 1'b1;
      start = (i == 1);
      tick();
    end
    start = 1'b0;
    in_valid = 1'b0;
    chk("ign:done", 32'(ba.done), 32'd1);
    chk("ign:sum", 32'(ba.sum_out), 32'd70);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign:done_clr", 32'(ba.done), 32'd0);
    chk("ign:busy_done_start", 32'(ba.busy), 32'd0);
    chk("ign:in_ready_idle", 32'(ba.in_ready), 32'd0);
    tick();
    chk("ign:no_extra_done", 32'(ba.done), 32'd0);
    chk("ign:sum_hold", 32'(ba.sum_out), 32'd70);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
